// File: rtl/shield_pkg.sv
// Shared types and default widths for the shield read/write AXI slave responders.
package shield_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        SEND
    } shield_rd_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int SHIELD_CL_ID_WIDTH         = 6;
    localparam int SHIELD_CL_DATA_WIDTH       = 64;
    localparam int SHIELD_LINE_WIDTH          = 512;
    localparam int SHIELD_OFFSET_WIDTH        = 6;
    localparam int SHIELD_BURSTS_PER_LINE     = 8;
    localparam int SHIELD_BURSTS_PER_LINE_LOG = 3;

endpackage

// File: rtl/shield_line_serializer.sv
// Holds one cache line and presents its beats in order from a start index,
// with a registered data output and a remaining-beat counter.
module shield_line_serializer
    import shield_pkg::*;
#(
    parameter int LINE_WIDTH          = SHIELD_LINE_WIDTH,
    parameter int CL_DATA_WIDTH       = SHIELD_CL_DATA_WIDTH,
    parameter int BURSTS_PER_LINE_LOG = SHIELD_BURSTS_PER_LINE_LOG
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_i,
    input  logic [LINE_WIDTH-1:0]          line_i,
    input  logic [BURSTS_PER_LINE_LOG-1:0] start_idx_i,
    input  logic [BURSTS_PER_LINE_LOG:0]   count_i,
    input  logic                           advance_i,
    output logic [CL_DATA_WIDTH-1:0]       rdata_o,
    output logic [BURSTS_PER_LINE_LOG:0]   remaining_o
);

    logic [LINE_WIDTH-1:0]          line_q, line_d;
    logic [BURSTS_PER_LINE_LOG-1:0] idx_q, idx_d;
    logic [BURSTS_PER_LINE_LOG:0]   rem_q, rem_d;
    logic [CL_DATA_WIDTH-1:0]       rdata_q, rdata_d;

    // rdata is re-registered on every index change so the R channel never
    // depends on a live mux from the line register.
    always_comb begin
        line_d  = line_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        rdata_d = rdata_q;
        if (load_i) begin
            line_d  = line_i;
            idx_d   = start_idx_i;
            rem_d   = count_i;
            rdata_d = line_i[start_idx_i*CL_DATA_WIDTH +: CL_DATA_WIDTH];
        end else if (advance_i) begin
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            rdata_d = line_q[idx_d*CL_DATA_WIDTH +: CL_DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            rdata_q <= '0;
        end else begin
            line_q  <= line_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign remaining_o = rem_q;

endmodule

// File: rtl/shield_read_slv.sv
// AXI R-channel responder: takes a per-line request plus one cache line and
// streams the selected beats, with rlast only on the final beat of the burst.
module shield_read_slv
    import shield_pkg::*;
#(
    parameter int CL_ID_WIDTH         = SHIELD_CL_ID_WIDTH,
    parameter int CL_DATA_WIDTH       = SHIELD_CL_DATA_WIDTH,
    parameter int LINE_WIDTH          = SHIELD_LINE_WIDTH,
    parameter int OFFSET_WIDTH        = SHIELD_OFFSET_WIDTH,
    parameter int BURSTS_PER_LINE     = SHIELD_BURSTS_PER_LINE,
    parameter int BURSTS_PER_LINE_LOG = SHIELD_BURSTS_PER_LINE_LOG
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [CL_ID_WIDTH-1:0]   s_axi_rid,
    output logic [CL_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic [7:0]               burst_count,
    input  logic [OFFSET_WIDTH-1:0]  burst_start_offset,
    input  logic [CL_ID_WIDTH-1:0]   burst_id,
    input  logic                     burst_last,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [LINE_WIDTH-1:0]    cache_line,
    input  logic                     cache_line_val,
    output logic                     cache_line_rdy
);

    localparam int CNT_W = BURSTS_PER_LINE_LOG + 1;

    // Beats to send, clipped at the end of the line (no wrap).
    function automatic logic [CNT_W-1:0] eff_count(input logic [7:0] cnt,
                                                   input logic [BURSTS_PER_LINE_LOG-1:0] idx);
        logic [8:0] room;
        room = 9'(BURSTS_PER_LINE) - {{(9-BURSTS_PER_LINE_LOG){1'b0}}, idx};
        if ({1'b0, cnt} < room) eff_count = CNT_W'(cnt);
        else                    eff_count = CNT_W'(room);
    endfunction

    shield_rd_state_t               state_q;
    logic                           req_rdy_q;
    logic                           line_rdy_q;
    logic                           rvalid_q;
    logic                           rlast_q;
    logic [CL_ID_WIDTH-1:0]         id_q;
    logic                           last_q;
    logic [BURSTS_PER_LINE_LOG-1:0] idx_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               remaining;
    logic [BURSTS_PER_LINE_LOG-1:0] req_idx;
    logic                           load;
    logic                           advance;
    logic                           unused_offset_lsbs;

    assign req_idx            = burst_start_offset[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG];
    assign unused_offset_lsbs = ^burst_start_offset[OFFSET_WIDTH-BURSTS_PER_LINE_LOG-1:0];

    assign load    = (state_q == WAIT_LINE) && cache_line_val;
    assign advance = (state_q == SEND) && rvalid_q && s_axi_rready;

    shield_line_serializer #(
        .LINE_WIDTH          (LINE_WIDTH),
        .CL_DATA_WIDTH       (CL_DATA_WIDTH),
        .BURSTS_PER_LINE_LOG (BURSTS_PER_LINE_LOG)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .line_i      (cache_line),
        .start_idx_i (idx_q),
        .count_i     (cnt_q),
        .advance_i   (advance),
        .rdata_o     (s_axi_rdata),
        .remaining_o (remaining)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_rdy_q  <= 1'b1;
            line_rdy_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            id_q       <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_val) begin
                        id_q       <= burst_id;
                        last_q     <= burst_last;
                        idx_q      <= req_idx;
                        cnt_q      <= eff_count(burst_count, req_idx);
                        req_rdy_q  <= 1'b0;
                        line_rdy_q <= 1'b1;
                        state_q    <= WAIT_LINE;
                    end
                end
                WAIT_LINE: begin
                    if (cache_line_val) begin
                        line_rdy_q <= 1'b0;
                        if (cnt_q == '0) begin
                            req_rdy_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            rvalid_q <= 1'b1;
                            rlast_q  <= last_q && (cnt_q == CNT_W'(1));
                            state_q  <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (advance) begin
                        if (remaining == CNT_W'(1)) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            req_rdy_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            rlast_q <= last_q && (remaining == CNT_W'(2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi_rid      = id_q;
    assign s_axi_rresp    = RESP_OKAY;
    assign s_axi_rlast    = rlast_q;
    assign s_axi_rvalid   = rvalid_q;
    assign req_rdy        = req_rdy_q;
    assign cache_line_rdy = line_rdy_q;

endmodule

// File: tb/tb_shield_read_slv.sv
// Directed bench for shield_read_slv with a beat-list model and a per-cycle R-channel checker.
module tb_shield_read_slv;

    logic         clk;
    logic         rst;
    logic [5:0]   s_axi_rid;
    logic [63:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [7:0]   burst_count;
    logic [5:0]   burst_start_offset;
    logic [5:0]   burst_id;
    logic         burst_last;
    logic         req_val;
    logic         req_rdy;
    logic [511:0] cache_line;
    logic         cache_line_val;
    logic         cache_line_rdy;

    shield_read_slv dut (
        .clk                (clk),
        .rst                (rst),
        .s_axi_rid          (s_axi_rid),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rlast        (s_axi_rlast),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .burst_count        (burst_count),
        .burst_start_offset (burst_start_offset),
        .burst_id           (burst_id),
        .burst_last         (burst_last),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .cache_line         (cache_line),
        .cache_line_val     (cache_line_val),
        .cache_line_rdy     (cache_line_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  id;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] got[$];
    int          checks   = 0;
    int          failures = 0;
    bit          rr_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k + 1);
        return l;
    endfunction

    // Model: the beats a request must produce, straight from the addressing rules.
    function automatic int model_push(input logic [7:0] cnt, input logic [5:0] off,
                                      input logic [5:0] id, input logic bl,
                                      input logic [511:0] line);
        int    first;
        int    n;
        beat_t b;
        first = int'(off) / 8;
        n     = (int'(cnt) < 8 - first) ? int'(cnt) : 8 - first;
        for (int i = 0; i < n; i++) begin
            b.data = line[(first + i)*64 +: 64];
            b.id   = id;
            b.last = bl && (i == n - 1);
            exp_q.push_back(b);
        end
        return n;
    endfunction

    // rready driver: held high, or toggled every cycle.
    initial begin
        s_axi_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_axi_rready = rr_toggle ? ~s_axi_rready : 1'b1;
        end
    end

    // Compare process: checks every accepted beat and R stability under backpressure.
    initial begin
        logic [63:0] p_data;
        logic [5:0]  p_id;
        logic        p_last;
        bit          have_prev;
        beat_t       e;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    chk("hold_rvalid", {63'b0, s_axi_rvalid}, 64'd1);
                    chk("hold_rdata", s_axi_rdata, p_data);
                    chk("hold_rid", {58'b0, s_axi_rid}, {58'b0, p_id});
                    chk("hold_rlast", {63'b0, s_axi_rlast}, {63'b0, p_last});
                    have_prev = 1'b0;
                end
                if (s_axi_rvalid) begin
                    if (!s_axi_rready) begin
                        p_data    = s_axi_rdata;
                        p_id      = s_axi_rid;
                        p_last    = s_axi_rlast;
                        have_prev = 1'b1;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual rdata=%0h required no beat", s_axi_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rid", {58'b0, s_axi_rid}, {58'b0, e.id});
                        chk("rlast", {63'b0, s_axi_rlast}, {63'b0, e.last});
                        chk("rresp", {62'b0, s_axi_rresp}, 64'd0);
                        got.push_back(s_axi_rdata);
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [7:0] cnt, input logic [5:0] off, input logic [5:0] id,
                            input logic bl, input logic [511:0] line, output int n);
        int w;
        w = 0;
        while (!req_rdy && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("req_rdy_wait", {63'b0, req_rdy}, 64'd1);
        burst_count        = cnt;
        burst_start_offset = off;
        burst_id           = id;
        burst_last         = bl;
        req_val            = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        n = model_push(cnt, off, id, bl, line);
        w = 0;
        while (!cache_line_rdy && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("line_rdy_wait", {63'b0, cache_line_rdy}, 64'd1);
        cache_line     = line;
        cache_line_val = 1'b1;
        @(posedge clk); #1;
        cache_line_val = 1'b0;
        chk("rvalid_latency", {63'b0, s_axi_rvalid}, {63'b0, n > 0});
    endtask

    task automatic run_burst(input logic [7:0] cnt, input logic [5:0] off, input logic [5:0] id,
                             input logic bl, input logic [511:0] line, input bit tog,
                             output int cycles);
        int n;
        rr_toggle = tog;
        got.delete();
        send_req(cnt, off, id, bl, line, n);
        cycles = 0;
        while (!(req_rdy && exp_q.size() == 0) && cycles < 200) begin
            @(posedge clk); #1; cycles++;
        end
        chk("burst_done", {63'b0, req_rdy && exp_q.size() == 0}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        rst                = 1'b1;
        req_val            = 1'b0;
        burst_count        = '0;
        burst_start_offset = '0;
        burst_id           = '0;
        burst_last         = 1'b0;
        cache_line         = '0;
        cache_line_val     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", {63'b0, s_axi_rvalid}, 64'd0);
        chk("rst_rlast", {63'b0, s_axi_rlast}, 64'd0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        chk("rst_rid", {58'b0, s_axi_rid}, 64'd0);
        chk("rst_rresp", {62'b0, s_axi_rresp}, 64'd0);
        chk("rst_req_rdy", {63'b0, req_rdy}, 64'd1);
        chk("rst_line_rdy", {63'b0, cache_line_rdy}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat with rlast.
        run_burst(8'd1, 6'b000000, 6'h2A, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t1_nbeats", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("t1_beat0", got[0], 64'd1);
        chk("t1_cycles", 64'(cyc), 64'd1);

        // Full line back-to-back.
        run_burst(8'd8, 6'b000000, 6'h11, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t2_nbeats", 64'(got.size()), 64'd8);
        for (int i = 0; i < got.size(); i++) chk("t2_beat", got[i], 64'(i + 1));
        chk("t2_cycles", 64'(cyc), 64'd8);

        // Mid-line start, then tail of line.
        run_burst(8'd3, 6'b001000, 6'h05, 1'b0, mk_line(64'd0), 1'b0, cyc);
        chk("t3a_nbeats", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size(); i++) chk("t3a_beat", got[i], 64'(i + 2));
        run_burst(8'd2, 6'b110000, 6'h05, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t3b_nbeats", 64'(got.size()), 64'd2);
        for (int i = 0; i < got.size(); i++) chk("t3b_beat", got[i], 64'(i + 7));

        // Saturation at line end.
        run_burst(8'd4, 6'b111000, 6'h3F, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t4_nbeats", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("t4_beat0", got[0], 64'd8);
        chk("t4_req_rdy", {63'b0, req_rdy}, 64'd1);

        // Backpressure, burst_last=0, low offset bits ignored.
        run_burst(8'd2, 6'b010101, 6'h09, 1'b0, mk_line(64'd0), 1'b1, cyc);
        chk("t5_nbeats", 64'(got.size()), 64'd2);
        for (int i = 0; i < got.size(); i++) chk("t5_beat", got[i], 64'(i + 3));

        // Zero count: no beats.
        run_burst(8'd0, 6'b000000, 6'h01, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t6_nbeats", 64'(got.size()), 64'd0);

        // Different line contents and a large count.
        run_burst(8'd200, 6'b011000, 6'h22, 1'b1, mk_line(64'hA000), 1'b0, cyc);
        chk("t7_nbeats", 64'(got.size()), 64'd5);
        if (got.size() == 5) chk("t7_beat4", got[4], 64'hA008);

        // Reset during the second beat of a full-line burst.
        rr_toggle = 1'b0;
        got.delete();
        send_req(8'd8, 6'b000000, 6'h17, 1'b1, mk_line(64'd0), n);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("rst_mid_rvalid", {63'b0, s_axi_rvalid}, 64'd0);
        chk("rst_mid_req_rdy", {63'b0, req_rdy}, 64'd1);
        chk("rst_mid_rdata", s_axi_rdata, 64'd0);
        chk("rst_mid_nbeats", 64'(got.size()), 64'd1);
        rst = 1'b0;
        run_burst(8'd1, 6'b100000, 6'h33, 1'b1, mk_line(64'd0), 1'b0, cyc);
        chk("t8_nbeats", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("t8_beat0", got[0], 64'd5);

        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_rvalid", {63'b0, s_axi_rvalid}, 64'd0);
        chk("model_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
